// File: rtl/mcs4_clockgen.sv
// mcs4_clockgen: two-phase non-overlapping clock generator and power-on-clear
// sequencer for the 4004 core, with halt / single-step at instruction-cycle
// boundaries (an instruction cycle is eight clk1/clk2 phase pairs).
module mcs4_clockgen #(
  parameter int CLK1_W     = 2,
  parameter int CLK2_W     = 2,
  parameter int GAP        = 1,
  parameter int POC_CYCLES = 16
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       poc_req,
  output logic       clk1_pad,
  output logic       clk2_pad,
  output logic       poc_pad,
  output logic [2:0] phase,
  output logic       halted
);

  localparam int MAXW = (CLK1_W > CLK2_W) ? ((CLK1_W > GAP) ? CLK1_W : GAP)
                                          : ((CLK2_W > GAP) ? CLK2_W : GAP);
  localparam int WCW  = $clog2(MAXW + 1);
  localparam int PCW  = $clog2(POC_CYCLES + 1);

  localparam logic [WCW-1:0] C1_LAST  = WCW'(CLK1_W - 1);
  localparam logic [WCW-1:0] C2_LAST  = WCW'(CLK2_W - 1);
  localparam logic [WCW-1:0] GAP_LAST = WCW'(GAP - 1);
  localparam logic [PCW-1:0] POC_LOAD = PCW'(POC_CYCLES);
  localparam logic [PCW-1:0] POC_ONE  = PCW'(1);

  typedef enum logic [2:0] {
    START = 3'd0,
    P1    = 3'd1,
    G1    = 3'd2,
    P2    = 3'd3,
    G2    = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t         state, state_next;
  logic [WCW-1:0] wcnt, wcnt_next;
  logic [PCW-1:0] poc_cnt;
  logic           step_pending;
  logic           boundary;
  logic           step_clear;
  logic           step_set;
  logic           phase_inc;

  // Next-state decode: width counting inside each pulse/gap, and the
  // run/step/POC decision at the end of the eighth phase pair.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt + 1'b1;
    boundary   = 1'b0;
    step_clear = 1'b0;
    case (state)
      START: begin
        state_next = P1;
        wcnt_next  = '0;
      end
      P1: begin
        if (wcnt == C1_LAST) begin
          state_next = G1;
          wcnt_next  = '0;
        end
      end
      G1: begin
        if (wcnt == GAP_LAST) begin
          state_next = P2;
          wcnt_next  = '0;
        end
      end
      P2: begin
        if (wcnt == C2_LAST) begin
          state_next = G2;
          wcnt_next  = '0;
        end
      end
      G2: begin
        if (wcnt == GAP_LAST) begin
          state_next = P1;
          wcnt_next  = '0;
          if (phase == 3'd0) begin
            boundary = 1'b1;
            if (!poc_pad && !run) begin
              if (step_pending) begin
                step_clear = 1'b1;
              end else begin
                state_next = HALT;
              end
            end
          end
        end
      end
      HALT: begin
        wcnt_next = '0;
        if (run || step_pending || poc_req || poc_pad) begin
          state_next = P1;
          step_clear = 1'b1;
        end
      end
      default: begin
        state_next = START;
        wcnt_next  = '0;
      end
    endcase
  end

  // A step request is latched only when it could actually release a cycle;
  // a new request wins over a same-cycle consume so none is lost.
  always_comb begin
    step_set  = step && !run && ((state == HALT) || !boundary);
    phase_inc = (state == P2) && (state_next == G2);
  end

  // Sequencer registers; pad outputs are registered from the next state so
  // they change cleanly on sysclk with no input-to-output paths.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= START;
      wcnt         <= '0;
      phase        <= 3'd0;
      step_pending <= 1'b0;
      clk1_pad     <= 1'b0;
      clk2_pad     <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state    <= state_next;
      wcnt     <= wcnt_next;
      clk1_pad <= (state_next == P1);
      clk2_pad <= (state_next == P2);
      halted   <= (state_next == HALT);
      if (phase_inc) begin
        phase <= phase + 3'd1;
      end
      if (step_set) begin
        step_pending <= 1'b1;
      end else if (step_clear) begin
        step_pending <= 1'b0;
      end
    end
  end

  // Power-on clear: counts boundaries down while active; a request reloads
  // and takes priority over a coincident decrement.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      poc_pad <= 1'b1;
      poc_cnt <= POC_LOAD;
    end else if (poc_req) begin
      poc_pad <= 1'b1;
      poc_cnt <= POC_LOAD;
    end else if (boundary && poc_pad) begin
      poc_cnt <= poc_cnt - 1'b1;
      if (poc_cnt == POC_ONE) begin
        poc_pad <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_clockgen.sv
// tb_mcs4_clockgen: directed stimulus against a position-in-period model of
// the clock generator, plus hand-computed literal checkpoints.
module tb_mcs4_clockgen;

  localparam int C1 = 2;
  localparam int C2 = 2;
  localparam int G  = 1;
  localparam int N  = 16;
  localparam int P  = C1 + C2 + 2 * G;

  logic       sysclk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       poc_req;
  logic       clk1_pad;
  logic       clk2_pad;
  logic       poc_pad;
  logic [2:0] phase;
  logic       halted;

  int total = 0;
  int bad   = 0;

  // model: mode 0=start 1=clocking 2=halted; t = position within a period
  int m_mode, m_t, m_phase, m_poc, m_pocn, m_pend, m_cyc;
  int m_bnd, m_set, m_cons;
  int pulses1 = 0;
  int pulses2 = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  logic check_en = 1'b0;

  mcs4_clockgen #(.CLK1_W(C1), .CLK2_W(C2), .GAP(G), .POC_CYCLES(N)) dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .run     (run),
    .step    (step),
    .poc_req (poc_req),
    .clk1_pad(clk1_pad),
    .clk2_pad(clk2_pad),
    .poc_pad (poc_pad),
    .phase   (phase),
    .halted  (halted)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model advanced on every sysclk edge.
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_phase = 0; m_poc = 1; m_pocn = N; m_pend = 0; m_cyc = 0;
    end else begin
      m_bnd  = (m_mode == 1 && m_t == P - 1 && m_phase == 0) ? 1 : 0;
      m_set  = (step && !run && (m_mode == 2 || m_bnd == 0)) ? 1 : 0;
      m_cons = 0;
      case (m_mode)
        0: begin m_mode = 1; m_t = 0; end
        1: begin
          if (m_t == P - 1) begin
            m_t = 0;
            if (m_bnd == 1 && m_poc == 0 && !run) begin
              if (m_pend == 1) m_cons = 1;
              else m_mode = 2;
            end
          end else begin
            m_t++;
            if (m_t == C1 + G + C2) m_phase = (m_phase + 1) % 8;
          end
        end
        default: begin
          if (run || m_pend == 1 || poc_req || m_poc == 1) begin
            m_mode = 1; m_t = 0; m_cons = 1;
          end
        end
      endcase
      if (m_set == 1) m_pend = 1;
      else if (m_cons == 1) m_pend = 0;
      if (poc_req) begin
        m_poc = 1; m_pocn = N;
      end else if (m_bnd == 1 && m_poc == 1) begin
        m_pocn--;
        if (m_pocn == 0) m_poc = 0;
      end
      m_cyc++;
    end
  end

  // Per-cycle comparison of all outputs against the model, plus pulse counts.
  always @(posedge sysclk) begin
    #1;
    if (check_en && rst_n) begin
      checkOutput("clk1_pad", int'(clk1_pad), (m_mode == 1 && m_t < C1) ? 1 : 0);
      checkOutput("clk2_pad", int'(clk2_pad),
                  (m_mode == 1 && m_t >= C1 + G && m_t < C1 + G + C2) ? 1 : 0);
      checkOutput("poc_pad", int'(poc_pad), m_poc);
      checkOutput("phase", int'(phase), m_phase);
      checkOutput("halted", int'(halted), (m_mode == 2) ? 1 : 0);
    end
    if (clk1_pad && !prev1) pulses1++;
    if (clk2_pad && !prev2) pulses2++;
    prev1 = clk1_pad;
    prev2 = clk2_pad;
  end

  task automatic applyStimulus(input logic r, input logic s, input logic p);
    @(posedge sysclk);
    #2;
    run = r; step = s; poc_req = p;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #2;
    end
  endtask

  task automatic toCycle(input int n);
    int guard;
    guard = 0;
    while (m_cyc < n && guard < 5000) begin
      @(posedge sysclk);
      #1;
      guard++;
    end
    if (guard >= 5000) checkOutput("to_cycle_timeout", m_cyc, n);
  endtask

  initial begin
    int s1, s2, guard;
    rst_n = 1'b1; run = 1'b1; step = 1'b0; poc_req = 1'b0;
    #3 rst_n = 1'b0;
    #4;
    checkOutput("reset_clk1", int'(clk1_pad), 0);
    checkOutput("reset_clk2", int'(clk2_pad), 0);
    checkOutput("reset_poc", int'(poc_pad), 1);
    checkOutput("reset_phase", int'(phase), 0);
    checkOutput("reset_halted", int'(halted), 0);
    repeat (2) @(posedge sysclk);
    #2 rst_n = 1'b1;
    check_en = 1'b1;

    // free-run timing literals
    toCycle(1);  checkOutput("lit_clk1_c1", int'(clk1_pad), 1);
    toCycle(3);  checkOutput("lit_clk1_c3", int'(clk1_pad), 0);
    toCycle(4);  checkOutput("lit_clk2_c4", int'(clk2_pad), 1);
    toCycle(6);  checkOutput("lit_phase_c6", int'(phase), 1);
    toCycle(7);  checkOutput("lit_clk1_c7", int'(clk1_pad), 1);
    toCycle(47); checkOutput("lit_phase_c47", int'(phase), 7);
    toCycle(48); checkOutput("lit_phase_c48", int'(phase), 0);
    toCycle(768); checkOutput("lit_poc_c768", int'(poc_pad), 1);
    toCycle(769); checkOutput("lit_poc_c769", int'(poc_pad), 0);

    // drop run: halt at the next boundary (cycle 816) and stay halted
    toCycle(790);
    #1;
    run = 1'b0;
    toCycle(816); checkOutput("lit_halted_c816", int'(halted), 0);
    toCycle(817); checkOutput("lit_halted_c817", int'(halted), 1);
    idle(1000);
    checkOutput("halted_after_1000", int'(halted), 1);

    // single step releases one instruction cycle
    s1 = pulses1; s2 = pulses2;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle(70);
    checkOutput("step_clk1_pulses", pulses1 - s1, 8);
    checkOutput("step_clk2_pulses", pulses2 - s2, 8);
    checkOutput("step_halted", int'(halted), 1);

    // extra steps during the released cycle coalesce into one more cycle
    s1 = pulses1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      idle(2);
    end
    idle(120);
    checkOutput("coalesce_clk1_pulses", pulses1 - s1, 16);
    checkOutput("coalesce_halted", int'(halted), 1);

    // poc_req while halted: 16 POC cycles plus one, then halt
    s1 = pulses1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pocreq_poc_next", int'(poc_pad), 1);
    idle(17 * 48 + 30);
    checkOutput("pocreq_clk1_pulses", pulses1 - s1, 17 * 8);
    checkOutput("pocreq_halted", int'(halted), 1);
    checkOutput("pocreq_poc_end", int'(poc_pad), 0);

    // asynchronous reset in the middle of a clk2 pulse
    run = 1'b1;
    guard = 0;
    do begin
      @(posedge sysclk);
      #1;
      guard++;
    end while (!clk2_pad && guard < 40);
    checkOutput("wait_clk2_high", int'(clk2_pad), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_clk2", int'(clk2_pad), 0);
    checkOutput("midreset_clk1", int'(clk1_pad), 0);
    checkOutput("midreset_poc", int'(poc_pad), 1);
    checkOutput("midreset_phase", int'(phase), 0);
    @(posedge sysclk);
    #2 rst_n = 1'b1;
    toCycle(1); checkOutput("restart_clk1_c1", int'(clk1_pad), 1);
    toCycle(4); checkOutput("restart_clk2_c4", int'(clk2_pad), 1);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
